// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared definitions for the serial pattern detector.
//   state_t      : detector state encoding (UNARMED / ARMED)
//   *_MIN/*_MAX  : legal limits for the PAT_W and CNT_W parameters
package seq_detector_pkg;

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } state_t;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial stream / pattern / status bundle for seq_detector_fsm.
//   x, x_valid  : serial data bit and its qualifier
//   pat         : pattern (pat[PAT_W-1] oldest bit, pat[0] newest)
//   pat_load    : capture pat and re-arm
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   z           : Mealy match indication
//   armed       : a pattern has been loaded since reset
//   match_cnt   : saturating match count
// master = stream source, slave = detector.
interface seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic [PAT_W-1:0] pat;
    logic             pat_load;
    logic             overlap;
    logic             z;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, pat, pat_load, overlap,
        input  z, armed, match_cnt
    );

    modport slave (
        input  x, x_valid, pat, pat_load, overlap,
        output z, armed, match_cnt
    );
endinterface

// File: rtl/seq_detector_sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones.
//   CLK  : clock, rising edge
//   CLR  : asynchronous active-low reset (count -> 0)
//   clr  : synchronous clear, has priority over inc
//   inc  : increment by one unless already all-ones
//   cnt  : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seq_detector_fsm.sv
// seq_detector_fsm: serial bit-pattern detector with a Mealy match output.
//   CLK : clock, rising edge
//   CLR : asynchronous active-low reset
//   bus : seq_detector_if slave (x/x_valid in, pat/pat_load/overlap in,
//         z/armed/match_cnt out)
// z rises in the same cycle the last pattern bit arrives. The window being
// compared is {hist, x}: the PAT_W-1 previously accepted bits plus the
// current bit. fill counts how many history bits are genuine, so a match
// can only fire once PAT_W real bits have been seen since the last restart.
// Build option SEQDET_MATCH_CNT_EN: when defined, match_cnt is a saturating
// count of matches; when undefined, match_cnt is tied to 0 and no counter
// flops exist.
module seq_detector_fsm
    import seq_detector_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic           CLK,
    input  logic           CLR,
    seq_detector_if.slave  bus
);
    localparam int             FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
        $error("seq_detector_fsm: PAT_W or CNT_W out of legal range");
    end

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat_reg, pat_n;
    logic [PAT_W-2:0]   hist, hist_n;
    logic [FW-1:0]      fill, fill_n;
    logic [PAT_W-1:0]   win;
    logic               z_c;

    // Newest bit lands in bit 0; dropping the MSB of the window gives the
    // shifted history for any PAT_W, including PAT_W=2.
    assign win = {hist, bus.x};

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= UNARMED;
            pat_reg <= '0;
            hist    <= '0;
            fill    <= '0;
        end else begin
            state   <= state_n;
            pat_reg <= pat_n;
            hist    <= hist_n;
            fill    <= fill_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_reg;
        hist_n  = hist;
        fill_n  = fill;
        z_c     = 1'b0;
        if (bus.pat_load) begin
            // Load wins over data: the current bit is discarded.
            pat_n   = bus.pat;
            hist_n  = '0;
            fill_n  = '0;
            state_n = ARMED;
        end else if (state == ARMED && bus.x_valid) begin
            z_c = (fill == FILL_MAX) && (win == pat_reg);
            if (z_c && !bus.overlap) begin
                // Non-overlapping: next match needs PAT_W fresh bits.
                hist_n = '0;
                fill_n = '0;
            end else begin
                hist_n = win[PAT_W-2:0];
                if (fill != FILL_MAX)
                    fill_n = fill + 1'b1;
            end
        end
    end

    assign bus.z     = z_c;
    assign bus.armed = (state == ARMED);

`ifdef SEQDET_MATCH_CNT_EN
    sat_counter #(.W(CNT_W)) u_cnt (
        .CLK (CLK),
        .CLR (CLR),
        .clr (bus.pat_load),
        .inc (z_c),
        .cnt (bus.match_cnt)
    );
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_fsm.sv
module tb_seq_detector_fsm;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detector_fsm #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ecnt(input int n);
        if (!CNT_EN) return 32'd0;
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit at the negedge and check the combinational z.
    task automatic bit_in(input logic xb, input logic v, input logic ez, input string tag);
        @(negedge CLK);
        bus.x = xb; bus.x_valid = v; bus.pat_load = 1'b0;
        #1 check(tag, {31'b0, bus.z}, {31'b0, ez});
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic ov);
        @(negedge CLK);
        bus.pat = p; bus.pat_load = 1'b1; bus.x_valid = 1'b0; bus.overlap = ov;
        #1 check("z_in_load", {31'b0, bus.z}, 32'd0);
    endtask

    task automatic idle();
        @(negedge CLK);
        bus.x_valid = 1'b0; bus.pat_load = 1'b0;
        #1;
    endtask

    initial begin
        bus.x = 0; bus.x_valid = 0; bus.pat = '0; bus.pat_load = 0; bus.overlap = 1;
        #3;
        check("rst_armed", {31'b0, bus.armed}, 32'd0);
        check("rst_z", {31'b0, bus.z}, 32'd0);
        check("rst_cnt", 32'(bus.match_cnt), 32'd0);
        @(negedge CLK); CLR = 1'b1;

        // 1: unarmed, stream ignored (pat change without load has no effect)
        bus.pat = 4'b0101;
        bit_in(1, 1, 0, "t1_b1"); bit_in(0, 1, 0, "t1_b2"); bit_in(1, 1, 0, "t1_b3");
        bit_in(0, 1, 0, "t1_b4"); bit_in(1, 1, 0, "t1_b5");
        idle();
        check("t1_armed", {31'b0, bus.armed}, 32'd0);
        check("t1_cnt", 32'(bus.match_cnt), 32'd0);

        // 2: overlapping 1011 over 1,0,1,1,0,1,1 -> z on bits 4 and 7
        load(4'b1011, 1'b1);
        bit_in(1, 1, 0, "t2_b1"); bit_in(0, 1, 0, "t2_b2"); bit_in(1, 1, 0, "t2_b3");
        bit_in(1, 1, 1, "t2_b4"); bit_in(0, 1, 0, "t2_b5"); bit_in(1, 1, 0, "t2_b6");
        bit_in(1, 1, 1, "t2_b7");
        idle();
        check("t2_armed", {31'b0, bus.armed}, 32'd1);
        check("t2_cnt", 32'(bus.match_cnt), ecnt(2));

        // 3: same stream non-overlapping -> z on bit 4 only
        load(4'b1011, 1'b0);
        idle();
        check("t3_cnt_cleared", 32'(bus.match_cnt), 32'd0);
        bit_in(1, 1, 0, "t3_b1"); bit_in(0, 1, 0, "t3_b2"); bit_in(1, 1, 0, "t3_b3");
        bit_in(1, 1, 1, "t3_b4"); bit_in(0, 1, 0, "t3_b5"); bit_in(1, 1, 0, "t3_b6");
        bit_in(1, 1, 0, "t3_b7");
        idle();
        check("t3_cnt", 32'(bus.match_cnt), ecnt(1));

        // 4: 1111 overlapping, invalid cycle mid-stream holds history
        load(4'b1111, 1'b1);
        bit_in(1, 1, 0, "t4_v1"); bit_in(1, 1, 0, "t4_v2"); bit_in(1, 1, 0, "t4_v3");
        bit_in(1, 1, 1, "t4_v4"); bit_in(1, 0, 0, "t4_inval");
        bit_in(1, 1, 1, "t4_v5"); bit_in(1, 1, 1, "t4_v6"); bit_in(1, 1, 1, "t4_v7");
        idle();
        check("t4_cnt_sat", 32'(bus.match_cnt), ecnt(4));

        // 5: pat_load on the 4th matching bit -> z=0, history restarts
        load(4'b1011, 1'b1);
        bit_in(1, 1, 0, "t5_b1"); bit_in(0, 1, 0, "t5_b2"); bit_in(1, 1, 0, "t5_b3");
        @(negedge CLK);
        bus.x = 1; bus.x_valid = 1; bus.pat = 4'b1011; bus.pat_load = 1;
        #1 check("t5_z_load_bit", {31'b0, bus.z}, 32'd0);
        idle();
        check("t5_cnt_after_load", 32'(bus.match_cnt), 32'd0);
        bit_in(1, 1, 0, "t5_r1"); bit_in(0, 1, 0, "t5_r2"); bit_in(1, 1, 0, "t5_r3");
        bit_in(1, 1, 1, "t5_r4");
        idle();
        check("t5_cnt_rematch", 32'(bus.match_cnt), ecnt(1));
        // CLR mid-stream: matching bit present, reset kills z immediately
        bit_in(0, 1, 0, "t5_c1"); bit_in(1, 1, 0, "t5_c2"); bit_in(1, 1, 1, "t5_c3");
        #1 CLR = 1'b0;
        #1;
        check("t5_clr_z", {31'b0, bus.z}, 32'd0);
        check("t5_clr_armed", {31'b0, bus.armed}, 32'd0);
        check("t5_clr_cnt", 32'(bus.match_cnt), 32'd0);
        @(negedge CLK); CLR = 1'b1;
        bit_in(1, 1, 0, "t5_post1"); bit_in(0, 1, 0, "t5_post2");
        bit_in(1, 1, 0, "t5_post3"); bit_in(1, 1, 0, "t5_post4");
        idle();
        check("t5_post_armed", {31'b0, bus.armed}, 32'd0);

        // 6: 0000 overlapping, ten zeros -> 7 matches, counter saturates at 3
        load(4'b0000, 1'b1);
        for (int i = 1; i <= 10; i++)
            bit_in(0, 1, (i >= 4), $sformatf("t6_b%0d", i));
        idle();
        check("t6_cnt_sat", 32'(bus.match_cnt), ecnt(7));
        idle();
        check("t6_cnt_hold", 32'(bus.match_cnt), ecnt(7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detector_fsm.md
Name: seq_detector_fsm

Overview:
Parametrised serial bit-pattern detector with a Mealy output, generalising the 4-state serial FSMs in this codebase. The block takes a 1-bit serial stream and a runtime-loadable pattern of PAT_W bits. It asserts z in the same cycle that the last pattern bit arrives. It supports overlapping and non-overlapping detection modes and an optional saturating match counter. It sits directly behind a serial input, and its output feeds downstream control logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter; legal range 1..16.

Ports:
CLK  input  1  clock; rising edge.
CLR  input  1  reset; asynchronous, active-low.
x  input  1  serial data bit.
x_valid  input  1  x is sampled only when this is 1.
pat  input  PAT_W  pattern; pat[PAT_W-1] is the oldest bit, pat[0] is matched against the newest bit.
pat_load  input  1  capture pat and re-arm the detector.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
z  output  1  match indication (Mealy, combinational).
armed  output  1  a pattern has been loaded since reset.
match_cnt  output  CNT_W  count of matches, saturating.

Behaviour:
- State register: UNARMED / ARMED, plus:
  - hist[PAT_W-2:0], the previous valid bits; hist[0] is the newest.
  - fill, a count of valid bits held, range 0..PAT_W-1.
  - pat_reg.
- Async reset (CLR=0): state=UNARMED, pat_reg=0, hist=0, fill=0, match_cnt=0. Therefore z=0 and armed=0.
- Reset asserted mid-stream discards all history immediately; no match is possible until the next pat_load.
- UNARMED: x and x_valid are ignored; z=0.
- pat_load=1 in any state, at the next edge: pat_reg<=pat, hist<=0, fill<=0, match_cnt<=0, state<=ARMED.
  - pat_load has priority over x_valid: in a load cycle z=0 and x is discarded.
- ARMED with x_valid=1 and pat_load=0:
  - z = (fill==PAT_W-1) && ({hist,x}==pat_reg), combinational in the same cycle; there is no added latency.
  - If z=1 and overlap=0: at the edge, hist<=0 and fill<=0, so the next match needs PAT_W fresh bits.
  - Otherwise: hist<={hist[PAT_W-3:0],x} and fill<=min(fill+1,PAT_W-1).
  - For PAT_W=2, hist is 1 bit and is simply loaded with x.
- x_valid=0: hist, fill and state hold; z=0.
- match_cnt increments by 1 at each edge where z=1, and saturates at all-ones; it never wraps.
- armed = (state==ARMED).
- A change of overlap mid-stream takes effect on the current cycle's match decision only; the history already held is unaffected.
- A pat change without pat_load has no effect.

Optional Feature:
Macro SEQDET_MATCH_CNT_EN.
- Defined: match_cnt is implemented as specified above.
- Undefined: no counter flops are implemented, the port remains, and match_cnt is tied to 0.

Decomposition:
- Shared package seq_detector_pkg holds:
  - the state encoding: UNARMED=1'b0, ARMED=1'b1;
  - localparams for the PAT_W and CNT_W legal limits.
- One natural sub-module: sat_counter (width CNT_W; inc, clr, async active-low CLR; saturating). It is instantiated only under SEQDET_MATCH_CNT_EN.

Test Plan:
1. Reset then stream x=1,0,1 with x_valid=1 and no pat_load -> z=0 throughout, armed=0, match_cnt=0.
2. PAT_W=4, load pat=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> z=1 on bit 4 and bit 7 only; match_cnt=2.
3. Same load and stream with overlap=0 -> z=1 on bit 4 only; match_cnt=1 (bits 5-7 supply only 3 fresh bits).
4. Load pat=4'b1111, overlap=1, stream seven 1s with x_valid low for one cycle mid-stream -> z=1 on valid bits 4, 5, 6, 7; z=0 in the invalid cycle.
5. pat_load asserted in the same cycle as the 4th matching bit -> z=0, match_cnt=0, fill restarts; assert CLR mid-stream -> armed=0 and z=0 immediately.
6. CNT_W=2, pat=4'b0000, overlap=1, stream ten 0s -> match_cnt reaches 3 and stays at 3.
